// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flush of IF_ID,
// and whole-pipe freeze while a multi-cycle data-memory access is outstanding.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt_addr,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             timeout_err
);

  localparam int SCNT_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES + 1) : 1;
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic flush;
    logic idex;
    logic bubble;
    logic exmem;
  } ctl_t;

  localparam ctl_t CTL_PASS   = '{pc: 1'b1, ifid: 1'b1, flush: 1'b0, idex: 1'b1, bubble: 1'b0, exmem: 1'b1};
  localparam ctl_t CTL_FREEZE = '{pc: 1'b0, ifid: 1'b0, flush: 1'b0, idex: 1'b0, bubble: 1'b0, exmem: 1'b0};
  localparam ctl_t CTL_BUBBLE = '{pc: 1'b0, ifid: 1'b0, flush: 1'b0, idex: 1'b1, bubble: 1'b1, exmem: 1'b1};

  state_t              cur_state, nxt_state;
  logic [SCNT_W-1:0]   scnt, scnt_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic                to_set;
  logic                apply_run, check_mem;
  ctl_t                ctl;

  logic load_haz, mem_stall;
  assign load_haz  = ex_mem_read && (ex_rt_addr != 5'd0) &&
                     ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    ctl       = CTL_PASS;
    nxt_state = cur_state;
    scnt_nxt  = scnt;
    wcnt_nxt  = wcnt;
    to_set    = 1'b0;
    apply_run = 1'b0;
    check_mem = 1'b0;

    case (cur_state)
      RUN: begin
        apply_run = 1'b1;
        check_mem = 1'b1;
      end
      STALL: begin
        if (mem_stall) begin
          ctl       = CTL_FREEZE;
          nxt_state = MEMWAIT;
          wcnt_nxt  = WCNT_W'(1);
        end else begin
          ctl      = CTL_BUBBLE;
          scnt_nxt = scnt - SCNT_W'(1);
          if (scnt == SCNT_W'(1)) nxt_state = RUN;
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          apply_run = 1'b1;
        end else if (wcnt >= WCNT_W'(MEM_TIMEOUT)) begin
          // Abandon the access: release the pipe and flag the error.
          to_set    = 1'b1;
          nxt_state = RUN;
        end else begin
          ctl      = CTL_FREEZE;
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        ctl       = CTL_FREEZE;
        nxt_state = RUN;
      end
    endcase

    // Shared RUN rules; also used on the MEMWAIT release cycle (minus the mem check).
    if (apply_run) begin
      if (check_mem && mem_stall) begin
        ctl       = CTL_FREEZE;
        nxt_state = MEMWAIT;
        wcnt_nxt  = WCNT_W'(1);
      end else if (load_haz) begin
        ctl = CTL_BUBBLE;
        if (LOAD_STALL_CYCLES > 1) begin
          nxt_state = STALL;
          scnt_nxt  = SCNT_W'(LOAD_STALL_CYCLES - 1);
        end else begin
          nxt_state = RUN;
        end
      end else begin
        ctl.flush = branch_taken;
        nxt_state = RUN;
      end
    end
  end

  // Enables are forced low combinationally while reset is held.
  assign pc_write    = !rst && ctl.pc;
  assign ifid_write  = !rst && ctl.ifid;
  assign ifid_flush  = !rst && ctl.flush;
  assign idex_write  = !rst && ctl.idex;
  assign idex_bubble = !rst && ctl.bubble;
  assign exmem_write = !rst && ctl.exmem;
  assign state       = cur_state;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= RUN;
      scnt        <= '0;
      wcnt        <= '0;
      stall_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      scnt      <= scnt_nxt;
      wcnt      <= wcnt_nxt;
      if (!ctl.pc && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (to_set)
        timeout_err <= 1'b1;
    end
  end

endmodule
